shift_sequencer: RTL and testbench

//   Multi-cycle controller for the 8-bit shift/ALU datapath.

---
 rtl/shift_seq_pkg.sv | 14 +
 rtl/shift_sequencer_if.sv | 26 ++
 rtl/shift_step.sv | 28 ++
 rtl/shift_sequencer.sv | 99 +++++++++
 tb/tb_shift_sequencer.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_seq_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = 3;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} seq_state_t;

    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;
    localparam logic SEL_LOAD     = 1'b0;
    localparam logic SEL_FEEDBACK = 1'b1;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the decode/control unit and the shift sequencer.
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
);
    logic             start;
    logic [WIDTH-1:0] operand;
    logic [AMT_W-1:0] amount;
    logic             dir;
    logic             arith;
    logic             shift_sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    modport master (
        output start, operand, amount, dir, arith,
        input  shift_sel, busy, done, result, carry_out
    );

    modport slave (
        input  start, operand, amount, dir, arith,
        output shift_sel, busy, done, result, carry_out
    );
endinterface

// File: rtl/shift_step.sv
// Combinational single-bit shifter used for each SHIFT cycle.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int unsigned W = WIDTH
) (
    input  logic [W-1:0] value,
    input  logic         dir,
    input  logic         arith,
    output logic [W-1:0] next_value_c,
    output logic         bit_out_c
);

    logic fill;

    // Sign fill only applies to right shifts; left shifts always bring in zero.
    always_comb begin
        fill = arith & value[W-1];
        if (dir == DIR_RIGHT) begin
            next_value_c = {fill, value[W-1:1]};
            bit_out_c    = value[0];
        end else begin
            next_value_c = {value[W-2:0], 1'b0};
            bit_out_c    = value[W-1];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift-by-N controller: one bit per cycle on a working register, Moore outputs.
module shift_sequencer
    import shift_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);

    seq_state_t       state_q, state_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             arith_q, arith_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             sel_q, sel_d;

    logic [WIDTH-1:0] step_value;
    logic             step_bit;

    shift_step #(.W(WIDTH)) u_step (
        .value        (result_q),
        .dir          (dir_q),
        .arith        (arith_q),
        .next_value_c (step_value),
        .bit_out_c    (step_bit)
    );

    // Next-state and register updates; status outputs are registered from the next state.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        dir_d    = dir_q;
        arith_d  = arith_q;
        result_d = result_q;
        carry_d  = carry_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    result_d = bus.operand;
                    count_d  = bus.amount;
                    dir_d    = bus.dir;
                    arith_d  = bus.arith;
                    carry_d  = 1'b0;
                    state_d  = (bus.amount != '0) ? SHIFT : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                result_d = step_value;
                carry_d  = step_bit;
                count_d  = AMT_W'(count_q - AMT_W'(1));
                if (count_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d == SHIFT);
        sel_d  = (state_d == SHIFT) ? SEL_FEEDBACK : SEL_LOAD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            dir_q    <= DIR_LEFT;
            arith_q  <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            sel_q    <= SEL_LOAD;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            arith_q  <= arith_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            sel_q    <= sel_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.shift_sel = sel_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer against an arithmetic shift model.
module tb_shift_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(8), .AMT_W(3)) bus ();

    shift_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: shift the whole operand by n at once with integer arithmetic.
    function automatic logic [8:0] model(input logic [7:0] op, input int n,
                                         input logic d, input logic a);
        int v;
        int r;
        int c;
        if (n == 0) return {1'b0, op};
        if (d == 1'b0) begin
            v = int'(op);
            r = (v << n) & 255;
            c = (v >> (8 - n)) & 1;
        end else begin
            v = a ? int'($signed(op)) : int'(op);
            r = (v >>> n) & 255;
            c = (v >>> (n - 1)) & 1;
        end
        return {c[0], r[7:0]};
    endfunction

    task automatic drive_start(input logic [7:0] op, input logic [2:0] amt,
                               input logic d, input logic a);
        bus.start   = 1'b1;
        bus.operand = op;
        bus.amount  = amt;
        bus.dir     = d;
        bus.arith   = a;
    endtask

    // Follows an operation already started at the last edge until Done (bounded).
    task automatic follow(input string tag, input int amt,
                          input logic [7:0] exp_res, input logic exp_carry,
                          input bit check_tail);
        int k = 1;
        int busy_cycles = 0;
        int sel_bad = 0;
        int done_at = 99;
        while (k <= 20) begin
            if (bus.shift_sel !== bus.busy) sel_bad++;
            if (bus.done === 1'b1) begin
                done_at = k;
                break;
            end
            if (bus.busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_latency"}, 32'(done_at), 32'(amt + 1));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(amt));
        check({tag, "_sel_vs_busy"}, 32'(sel_bad), 32'd0);
        check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
        check({tag, "_carry"}, 32'(bus.carry_out), 32'(exp_carry));
        if (check_tail) begin
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, 32'({bus.done, bus.busy, bus.shift_sel}), 32'd0);
            check({tag, "_hold"}, 32'({bus.carry_out, bus.result}), 32'({exp_carry, exp_res}));
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] op, input logic [2:0] amt,
                          input logic d, input logic a,
                          input logic [7:0] exp_res, input logic exp_carry);
        @(negedge clk);
        drive_start(op, amt, d, a);
        @(posedge clk); #1;
        bus.start = 1'b0;
        follow(tag, int'(amt), exp_res, exp_carry, 1'b1);
    endtask

    initial begin
        logic [8:0] m;
        logic [7:0] op;
        logic [2:0] amt;
        logic       d;
        logic       a;

        reset = 1'b1;
        drive_start(8'h00, 3'd0, 1'b0, 1'b0);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({bus.done, bus.busy, bus.shift_sel, bus.carry_out, bus.result}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("t1_left3",   8'h96, 3'd3, 1'b0, 1'b0, 8'hB0, 1'b0);
        run_op("t2_asr2",    8'h96, 3'd2, 1'b1, 1'b1, 8'hE5, 1'b1);
        run_op("t3_lsr7",    8'h81, 3'd7, 1'b1, 1'b0, 8'h01, 1'b0);
        run_op("t4_amt0",    8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A, 1'b0);
        run_op("t4b_left_arith_ignored", 8'hC3, 3'd1, 1'b0, 1'b1, 8'h86, 1'b1);

        // Start during SHIFT is ignored; Start in the DONE cycle chains a new operation.
        @(negedge clk);
        drive_start(8'h0F, 3'd4, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_start(8'hFF, 3'd2, 1'b1, 1'b1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        follow("t5_first", 3, 8'hF0, 1'b0, 1'b0);
        drive_start(8'h80, 3'd1, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        follow("t5_second", 1, 8'h00, 1'b1, 1'b1);

        // Reset in the second SHIFT cycle of a 5-step operation.
        @(negedge clk);
        drive_start(8'hA5, 3'd5, 1'b1, 1'b1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_reset_mid_shift",
              32'({bus.done, bus.busy, bus.shift_sel, bus.carry_out, bus.result}), 32'd0);
        reset = 1'b0;
        run_op("t6_after_reset", 8'h3C, 3'd2, 1'b1, 1'b0, 8'h0F, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op  = 8'($urandom);
            amt = 3'($urandom_range(0, 7));
            d   = 1'($urandom);
            a   = 1'($urandom);
            m   = model(op, int'(amt), d, a);
            run_op($sformatf("rand%0d", i), op, amt, d, a, m[7:0], m[8]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
